// File: rtl/sum_result_display.sv
// sum_result_display: captures the calculator's sum on each rising edge of done and shows it
// in hex on an 8-digit multiplexed 7-segment display. Define SUM_DISP_LZB_EN for leading-zero blanking.
module sum_result_display #(
  parameter int DATA_WIDTH = 32,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] sum_in,
  input  logic                  clear,
  output logic [7:0]            seg,
  output logic [7:0]            an,
  output logic                  result_valid,
  output logic [7:0]            capture_cnt
);

  localparam int DIGITS = DATA_WIDTH / 4;
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);

  logic                  done_d;
  logic [DATA_WIDTH-1:0] cap_reg;
  logic [DIV_W-1:0]      div_cnt;
  logic [2:0]            idx;
  logic                  capture;
  logic [3:0]            nib;
  logic [7:0]            hex_seg;
  logic [7:0]            seg_next;
  logic [7:0]            an_next;
  logic                  lz_blank;

  // done is a level; only the first sampled-high cycle counts as a completion.
  assign capture = done & ~done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_d       <= 1'b1;
      cap_reg      <= '0;
      result_valid <= 1'b0;
      capture_cnt  <= 8'd0;
    end else begin
      done_d <= done;
      if (clear) begin
        cap_reg      <= '0;
        result_valid <= 1'b0;
        capture_cnt  <= 8'd0;
      end else if (capture) begin
        cap_reg      <= sum_in;
        result_valid <= 1'b1;
        if (capture_cnt != 8'hFF) capture_cnt <= capture_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      idx     <= 3'd0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign nib = cap_reg[{idx, 2'b00} +: 4];

  always_comb begin
    hex_seg = 8'hFF;
    case (nib)
      4'h0: hex_seg = 8'hC0;
      4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;
      4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;
      4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;
      4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;
      4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;
      4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;
      4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;
      default: hex_seg = 8'h8E;
    endcase
  end

`ifdef SUM_DISP_LZB_EN
  // Highest non-zero nibble; digit 0 is never blanked, so msd stays 0 for a zero value.
  logic [2:0] msd;
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < DIGITS; i++) begin
      if (cap_reg[4*i +: 4] != 4'h0) msd = 3'(i);
    end
  end
  assign lz_blank = (idx > msd);
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    an_next  = ~(8'b1 << idx);
    seg_next = 8'hBF;
    if (result_valid) seg_next = lz_blank ? 8'hFF : hex_seg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= 8'hFF;
      an  <= 8'hFF;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_sum_result_display.sv
// Bench for sum_result_display: directed scenarios plus random traffic against a cycle-count display model.
module tb_sum_result_display;

  localparam int DW     = 32;
  localparam int SD     = 4;
  localparam int DIGITS = DW / 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          done = 1'b1;
  logic          clear = 1'b0;
  logic [DW-1:0] sum_in = '0;
  logic [7:0]    seg;
  logic [7:0]    an;
  logic          result_valid;
  logic [7:0]    capture_cnt;

  sum_result_display #(.DATA_WIDTH(DW), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .done(done), .sum_in(sum_in), .clear(clear),
    .seg(seg), .an(an), .result_valid(result_valid), .capture_cnt(capture_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] dec_tab [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state: what has been captured, and clock edges since reset release.
  logic          m_prev_done;
  logic [DW-1:0] m_cap;
  logic          m_valid;
  int            m_cnt;
  int            k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic valid, input logic [DW-1:0] cap, input int digit);
    int hi = 0;
    if (!valid) return 8'hBF;
    for (int d = 0; d < DIGITS; d++) if (((cap >> (4 * d)) & 32'hF) != 0) hi = d;
`ifdef SUM_DISP_LZB_EN
    if (digit > hi) return 8'hFF;
`endif
    return dec_tab[(cap >> (4 * digit)) & 32'hF];
  endfunction

  task automatic model_reset();
    m_prev_done = 1'b1;
    m_cap       = '0;
    m_valid     = 1'b0;
    m_cnt       = 0;
    k           = 0;
  endtask

  // One clock: drive inputs, take the edge, check registered outputs 1ns later.
  task automatic step(input logic d, input logic [DW-1:0] s, input logic c);
    int digit;
    logic [7:0] e_seg, e_an;
    done = d; sum_in = s; clear = c;
    @(posedge clk);
    k++;
    // Display shows the slot that was active before this edge, with the result held then.
    digit = ((k - 1) / SD) % DIGITS;
    e_an  = ~(8'h01 << digit);
    e_seg = exp_seg(m_valid, m_cap, digit);
    if (c) begin
      m_cap = '0; m_valid = 1'b0; m_cnt = 0;
    end else if (d && !m_prev_done) begin
      m_cap = s; m_valid = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    m_prev_done = d;
    #1;
    chk("seg", {24'd0, seg}, {24'd0, e_seg});
    chk("an", {24'd0, an}, {24'd0, e_an});
    chk("result_valid", {31'd0, result_valid}, {31'd0, m_valid});
    chk("capture_cnt", {24'd0, capture_cnt}, m_cnt);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg"}, {24'd0, seg}, 32'hFF);
    chk({tag, "_an"}, {24'd0, an}, 32'hFF);
    chk({tag, "_valid"}, {31'd0, result_valid}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, capture_cnt}, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] r;
    model_reset();

    // 1. Reset with done already high; no capture after release.
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    rst = 1'b1;
    repeat (40) step(1'b1, $urandom, 1'b0);
    chk("no_capture_after_release", {24'd0, capture_cnt}, 32'd0);

    // 2. Capture 0x1388 and watch all eight slots.
    step(1'b0, '0, 1'b0);
    step(1'b1, 32'h00001388, 1'b0);
    chk("first_capture_valid", {31'd0, result_valid}, 32'd1);
    repeat (34) step(1'b1, 32'h00001388, 1'b0);

    // 3. Held done ignores new sum_in; a fresh edge captures all-F.
    repeat (20) step(1'b1, 32'hFFFFFFFF, 1'b0);
    chk("held_done_cnt", {24'd0, capture_cnt}, 32'd1);
    step(1'b0, 32'hFFFFFFFF, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 1'b0);
    chk("second_capture_cnt", {24'd0, capture_cnt}, 32'd2);
    repeat (34) step(1'b1, 32'hFFFFFFFF, 1'b0);

    // 4. Clear in the same cycle as a done edge wins.
    step(1'b0, 32'h5, 1'b0);
    step(1'b1, 32'h5, 1'b1);
    chk("clear_collision_valid", {31'd0, result_valid}, 32'd0);
    chk("clear_collision_cnt", {24'd0, capture_cnt}, 32'd0);
    repeat (34) step(1'b1, 32'h5, 1'b0);

    // 5. Saturation after 300 pulses.
    for (int i = 0; i < 300; i++) begin
      step(1'b0, $urandom, 1'b0);
      step(1'b1, $urandom, 1'b0);
    end
    chk("saturated_cnt", {24'd0, capture_cnt}, 32'd255);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h00001388, 1'b0);
    chk("saturated_hold", {24'd0, capture_cnt}, 32'd255);
    repeat (34) step(1'b1, 32'h00001388, 1'b0);

    // Zero value exercises leading-zero handling on every digit.
    step(1'b0, 32'h0, 1'b0);
    repeat (34) step(1'b1, 32'h0, 1'b0);

    // Random traffic with values of assorted magnitudes.
    for (int i = 0; i < 400; i++) begin
      r = $urandom >> $urandom_range(0, 31);
      step(($urandom_range(0, 3) != 0), r, ($urandom_range(0, 31) == 0));
    end

    // Async reset mid-scan blanks outputs without a clock edge.
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midscan_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h00ABCDEF, 1'b0);
    repeat (34) step(1'b1, 32'h00ABCDEF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_result_display.md
Name: sum_result_display

Overview:
- Downstream consumer of the summation calculator.
- Watches the calculator's done flag and captures its sum output on each new completion.
- Holds the captured value and shows it in hex on the board's 8-digit multiplexed 7-segment display.
- Also reports a result-valid flag and a saturating count of completed calculations.

Parameters:
- DATA_WIDTH, 32: width of sum_in. Must be a multiple of 4 and at most 32. Displayed digits DIGITS = DATA_WIDTH/4.
- SCAN_DIV, 100000: clk cycles per digit slot. Minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- done  input  1  completion flag from the calculator; level signal, may stay high for many cycles.
- sum_in  input  DATA_WIDTH  calculator result; valid whenever done=1.
- clear  input  1  synchronous clear of captured result and counters.
- seg  output  8  segment drive, active-low. seg[6:0]=g..a, seg[7]=dp.
- an  output  8  digit enables, active-low. an[0] is the least significant digit.
- result_valid  output  1  high once a result has been captured since reset/clear.
- capture_cnt  output  8  number of captures, saturating at 255.

Behaviour:
- Reset (rst=0, async):
  - cap_reg=0, result_valid=0, capture_cnt=0.
  - Divider=0, digit index idx=0.
  - seg=8'hFF, an=8'hFF.
  - done_d=1, so a done level already high at reset release does not capture.
- Edge detect:
  - done_d <= done every cycle.
  - Capture event = done & ~done_d, i.e. the first cycle done is sampled high.
  - On capture: cap_reg <= sum_in, result_valid <= 1, capture_cnt <= capture_cnt+1 (held at 255 once reached). All registered; visible the cycle after the edge.
  - done held high: exactly one capture. sum_in changes while done stays high are ignored.
- clear (synchronous):
  - cap_reg <= 0, result_valid <= 0, capture_cnt <= 0.
  - clear and a capture event in the same cycle: clear wins, the event is dropped, and done_d still updates.
  - Does not affect the scan divider or idx.
- Scan:
  - Divider counts 0..SCAN_DIV-1 and wraps.
  - On the terminal count, idx <= (idx==DIGITS-1) ? 0 : idx+1.
- Outputs (registered, one cycle after idx/cap_reg change):
  - an = ~(8'b1 << idx). Anodes at or above DIGITS are always 1.
  - result_valid=0: seg=8'hBF ('-') on every digit.
  - result_valid=1: seg = hex decode of cap_reg[4*idx+3:4*idx], with dp=1 (off).
  - Decode table: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Reset asserted mid-scan: outputs blank immediately (async). Scanning restarts at idx=0 after release.

Optional Feature:
- Macro: SUM_DISP_LZB_EN (leading-zero blanking).
- Defined:
  - With result_valid=1, any digit more significant than the highest non-zero nibble of cap_reg shows seg=8'hFF.
  - Digit 0 is always shown, so a value of 0 displays a single '0'.
  - Its anode is still driven; only the segments blank.
  - The blank mask is computed combinationally from cap_reg and registered with seg.
- Undefined: all DIGITS digits shown, including leading zeros.

Test Plan (SCAN_DIV=4, DATA_WIDTH=32):
1. Reset/idle:
   - Stimulus: hold rst=0 with done=1, then release rst.
   - Required: during reset seg=FF, an=FF, result_valid=0, capture_cnt=0. After release, no capture occurs. Every slot shows seg=BF, and an cycles FE,FD,…,7F every 4 clocks.
2. Capture:
   - Stimulus: sum_in=32'h00001388, then done 0→1.
   - Required: one cycle later result_valid=1, capture_cnt=1. Digit slots 0..7 show 80,80,B0,F9,C0,C0,C0,C0.
3. Held done:
   - Stimulus: keep done=1 for 20 cycles while sum_in changes to 32'hFFFFFFFF.
   - Required: capture_cnt stays 1 and the display is unchanged. Then drop done, raise it again with sum_in=32'hFFFFFFFF: capture_cnt=2, all digits show 8E.
4. Clear collision:
   - Stimulus: assert clear in the same cycle done rises (sum_in=32'h5).
   - Required: result_valid=0, capture_cnt=0, display shows BF on all digits.
5. Saturation:
   - Stimulus: 300 separate done pulses.
   - Required: capture_cnt=255 and stays there.
6. SUM_DISP_LZB_EN defined:
   - Stimulus: capture 32'h00001388.
   - Required: digits 4–7 show FF, digits 0–3 as in case 2. Capturing 0 shows C0 on digit 0 and FF on the rest. Asserting rst mid-scan forces seg=FF, an=FF in the same cycle.
